// File: rtl/triggerrec_pkg.sv
// rtl/triggerrec_pkg.sv - shared types and constants for the trigger recorder drain path
package triggerrec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_WAIT,
        ST_TRAIL
    } drain_state_t;

    localparam logic [7:0] TRAILER_MAGIC = 8'hE7;
    localparam int         EVENT_W       = 64;

endpackage

// File: rtl/triggerrec_drain.sv
// rtl/triggerrec_drain.sv - pops 64-bit events and streams them as 32-bit words in trailer-closed bursts
module triggerrec_drain
    import triggerrec_pkg::*;
#(
    parameter int BURST_MAX = 16,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 cfg_enable,
    input  logic [7:0]           cfg_burst_len,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    input  logic                 fifo_nempty,
    input  logic [EVENT_W-1:0]   fifo_data,
    output logic                 fifo_pop,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic [31:0]          event_count
);

    drain_state_t         state, state_nx;
    logic [EVENT_W-1:0]   ev, ev_nx;
    logic [7:0]           n, n_nx;
    logic [TIMEOUT_W-1:0] timer, timer_nx;
    logic [15:0]          seq, seq_nx;
    logic [31:0]          count_nx;
    logic                 pop_nx, valid_nx, last_nx;
    logic [31:0]          data_nx;

    logic                 take;
    logic [8:0]           burst_eff;
    logic [8:0]           n_inc;

    assign take      = cfg_enable && fifo_nempty;
    assign burst_eff = (cfg_burst_len == 8'd0) ? 9'(BURST_MAX) : {1'b0, cfg_burst_len};
    assign n_inc     = {1'b0, n} + 9'd1;

    // Every output is computed one cycle ahead and registered, so nothing
    // downstream sees a combinational path from out_ready or the FIFO.
    always_comb begin
        state_nx = state;
        ev_nx    = ev;
        n_nx     = n;
        timer_nx = timer;
        seq_nx   = seq;
        count_nx = event_count;
        pop_nx   = 1'b0;
        valid_nx = out_valid;
        data_nx  = out_data;
        last_nx  = out_last;

        unique case (state)
            ST_IDLE: begin
                n_nx     = 8'd0;
                timer_nx = '0;
                if (take) begin
                    ev_nx    = fifo_data;
                    state_nx = ST_HI;
                    pop_nx   = 1'b1;
                    valid_nx = 1'b1;
                    data_nx  = fifo_data[63:32];
                    last_nx  = 1'b0;
                end
            end
            ST_HI: begin
                if (out_ready) begin
                    state_nx = ST_LO;
                    data_nx  = ev[31:0];
                end
            end
            ST_LO: begin
                if (out_ready) begin
                    n_nx     = n_inc[7:0];
                    count_nx = event_count + 32'd1;
                    if (n_inc == burst_eff) begin
                        state_nx = ST_TRAIL;
                        data_nx  = {TRAILER_MAGIC, n_inc[7:0], seq};
                        last_nx  = 1'b1;
                    end else begin
                        state_nx = ST_WAIT;
                        timer_nx = '0;
                        valid_nx = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                if (!cfg_enable || (!take && timer >= cfg_timeout)) begin
                    state_nx = ST_TRAIL;
                    valid_nx = 1'b1;
                    data_nx  = {TRAILER_MAGIC, n, seq};
                    last_nx  = 1'b1;
                end else if (take) begin
                    ev_nx    = fifo_data;
                    state_nx = ST_HI;
                    timer_nx = '0;
                    pop_nx   = 1'b1;
                    valid_nx = 1'b1;
                    data_nx  = fifo_data[63:32];
                    last_nx  = 1'b0;
                end else if (timer != {TIMEOUT_W{1'b1}}) begin
                    timer_nx = timer + 1'b1;
                end
            end
            ST_TRAIL: begin
                if (out_ready) begin
                    state_nx = ST_IDLE;
                    seq_nx   = seq + 16'd1;
                    n_nx     = 8'd0;
                    valid_nx = 1'b0;
                    last_nx  = 1'b0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            ev          <= '0;
            n           <= 8'd0;
            timer       <= '0;
            seq         <= 16'd0;
            event_count <= 32'd0;
            fifo_pop    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= 32'd0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            ev          <= ev_nx;
            n           <= n_nx;
            timer       <= timer_nx;
            seq         <= seq_nx;
            event_count <= count_nx;
            fifo_pop    <= pop_nx;
            out_valid   <= valid_nx;
            out_data    <= data_nx;
            out_last    <= last_nx;
            busy        <= (state_nx != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_triggerrec_drain.sv
// tb/tb_triggerrec_drain.sv - directed self-checking bench for triggerrec_drain
module tb_triggerrec_drain;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_enable = 1'b0;
    logic [7:0]  cfg_burst_len = 8'd0;
    logic [15:0] cfg_timeout = 16'd0;
    logic        fifo_nempty;
    logic [63:0] fifo_data;
    logic        fifo_pop;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic [31:0] event_count;

    triggerrec_drain #(.BURST_MAX(16), .TIMEOUT_W(16)) dut (
        .clk(clk), .resetn(resetn), .cfg_enable(cfg_enable),
        .cfg_burst_len(cfg_burst_len), .cfg_timeout(cfg_timeout),
        .fifo_nempty(fifo_nempty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .event_count(event_count)
    );

    always #5 clk = ~clk;

    // FWFT FIFO model: writes from the stimulus process, reads from the monitor.
    logic [63:0] fifo_mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    assign fifo_nempty = (wr_ptr != rd_ptr);
    assign fifo_data   = fifo_mem[rd_ptr % 64];

    logic [31:0] cap_data [0:255];
    logic        cap_last [0:255];
    int          cap_cyc  [0:255];
    int          cap_cnt = 0;
    int          cyc = 0;
    int          pop_cnt = 0;
    int          consec_pops = 0;
    int          stab_viol = 0;
    int          rdy_mode = 0;
    logic        prev_pop = 1'b0;
    logic        stalled = 1'b0;
    logic [31:0] st_data = 32'd0;
    logic        st_last = 1'b0;

    int checks = 0;
    int errors = 0;

    // Ready is chosen here first, so a captured word is the one the DUT
    // accepts at the following rising edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (stalled && resetn) begin
            if (!out_valid || out_data !== st_data || out_last !== st_last)
                stab_viol = stab_viol + 1;
        end
        stalled = out_valid && !out_ready;
        st_data = out_data;
        st_last = out_last;
        if (out_valid && out_ready && cap_cnt < 256) begin
            cap_data[cap_cnt] = out_data;
            cap_last[cap_cnt] = out_last;
            cap_cyc[cap_cnt]  = cyc;
            cap_cnt = cap_cnt + 1;
        end
        if (fifo_pop) begin
            pop_cnt = pop_cnt + 1;
            if (prev_pop) consec_pops = consec_pops + 1;
            rd_ptr = rd_ptr + 1;
        end
        prev_pop = fifo_pop;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] ev);
        fifo_mem[wr_ptr % 64] = ev;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic wait_words(input int target, input string name);
        for (int i = 0; i < 3000 && cap_cnt < target; i++) tick();
        checks++;
        if (cap_cnt < target) begin
            errors++;
            $display("FAIL %s timeout words got %0d want %0d", name, cap_cnt, target);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500 && busy; i++) tick();
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        checks++;
        if (fifo_pop !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got pop=%b valid=%b last=%b busy=%b want 0", fifo_pop, out_valid, out_last, busy);
        end
        checks++;
        if (out_data !== 32'd0 || event_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got data=%h count=%0d want 0", out_data, event_count);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int base;
        logic [31:0] ew [3] = '{32'h1111_2222, 32'h3333_4444, 32'hE701_0000};
        logic        el [3] = '{1'b0, 1'b0, 1'b1};
        cfg_enable = 1'b1;
        cfg_burst_len = 8'd0;
        cfg_timeout = 16'd4;
        rdy_mode = 0;
        base = cap_cnt;
        push(64'h1111_2222_3333_4444);
        tick();
        checks++;
        if (fifo_pop !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'h1111_2222) begin
            errors++;
            $display("FAIL single_latency got pop=%b valid=%b data=%h want 1 1 11112222", fifo_pop, out_valid, out_data);
        end
        wait_words(base + 3, "single");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cap_data[base+i] !== ew[i] || cap_last[base+i] !== el[i]) begin
                errors++;
                $display("FAIL single_word[%0d] got %h/%b want %h/%b", i, cap_data[base+i], cap_last[base+i], ew[i], el[i]);
            end
        end
        checks++;
        if (cap_cyc[base+2] - cap_cyc[base+1] !== 6) begin
            errors++;
            $display("FAIL single_timeout_gap got %0d want 6", cap_cyc[base+2] - cap_cyc[base+1]);
        end
        wait_idle();
        checks++;
        if (event_count !== 32'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_count got count=%0d busy=%b want 1 0", event_count, busy);
        end
    endtask

    task automatic test_burst_limit();
        int base, pbase;
        logic [31:0] ew [$];
        logic        el [$];
        do_reset();
        cfg_enable = 1'b1;
        cfg_burst_len = 8'd3;
        cfg_timeout = 16'd4;
        base = cap_cnt;
        pbase = pop_cnt;
        for (int i = 0; i < 7; i++) begin
            push({32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)});
            ew.push_back(32'hA000_0000 + 32'(i)); el.push_back(1'b0);
            ew.push_back(32'hB000_0000 + 32'(i)); el.push_back(1'b0);
            if (i == 2) begin ew.push_back(32'hE703_0000); el.push_back(1'b1); end
            if (i == 5) begin ew.push_back(32'hE703_0001); el.push_back(1'b1); end
        end
        ew.push_back(32'hE701_0002); el.push_back(1'b1);
        wait_words(base + 17, "burst");
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (cap_data[base+i] !== ew[i] || cap_last[base+i] !== el[i]) begin
                errors++;
                $display("FAIL burst_word[%0d] got %h/%b want %h/%b", i, cap_data[base+i], cap_last[base+i], ew[i], el[i]);
            end
        end
        wait_idle();
        checks++;
        if (pop_cnt - pbase !== 7 || consec_pops !== 0 || event_count !== 32'd7) begin
            errors++;
            $display("FAIL burst_pops got pops=%0d consec=%0d count=%0d want 7 0 7", pop_cnt - pbase, consec_pops, event_count);
        end
    endtask

    task automatic test_backpressure();
        int base, pbase;
        logic [31:0] ew [$];
        logic        el [$];
        cfg_burst_len = 8'd2;
        cfg_timeout = 16'd3;
        rdy_mode = 1;
        base = cap_cnt;
        pbase = pop_cnt;
        for (int i = 0; i < 5; i++) begin
            push({32'hC000_0000 + 32'(i), 32'hD000_0000 + 32'(i)});
            ew.push_back(32'hC000_0000 + 32'(i)); el.push_back(1'b0);
            ew.push_back(32'hD000_0000 + 32'(i)); el.push_back(1'b0);
            if (i == 1) begin ew.push_back(32'hE702_0003); el.push_back(1'b1); end
            if (i == 3) begin ew.push_back(32'hE702_0004); el.push_back(1'b1); end
        end
        ew.push_back(32'hE701_0005); el.push_back(1'b1);
        wait_words(base + 13, "backpressure");
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (cap_data[base+i] !== ew[i] || cap_last[base+i] !== el[i]) begin
                errors++;
                $display("FAIL bp_word[%0d] got %h/%b want %h/%b", i, cap_data[base+i], cap_last[base+i], ew[i], el[i]);
            end
        end
        rdy_mode = 0;
        wait_idle();
        checks++;
        if (stab_viol !== 0 || pop_cnt - pbase !== 5 || consec_pops !== 0 || cap_cnt !== base + 13) begin
            errors++;
            $display("FAIL bp_integrity got viol=%0d pops=%0d consec=%0d words=%0d want 0 5 0 13",
                     stab_viol, pop_cnt - pbase, consec_pops, cap_cnt - base);
        end
    endtask

    task automatic test_disable();
        int base;
        logic [31:0] ew [6] = '{32'hE000_0001, 32'hE000_0002, 32'hE701_0006,
                                32'hF000_0001, 32'hF000_0002, 32'hE701_0007};
        logic        el [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        cfg_burst_len = 8'd0;
        cfg_timeout = 16'd3;
        base = cap_cnt;
        push(64'hE000_0001_E000_0002);
        push(64'hF000_0001_F000_0002);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        cfg_enable = 1'b0;
        wait_words(base + 3, "disable");
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (cap_cnt !== base + 3 || busy !== 1'b0 || fifo_nempty !== 1'b1) begin
            errors++;
            $display("FAIL disable_idle got words=%0d busy=%b nempty=%b want 3 0 1", cap_cnt - base, busy, fifo_nempty);
        end
        cfg_enable = 1'b1;
        wait_words(base + 6, "reenable");
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (cap_data[base+i] !== ew[i] || cap_last[base+i] !== el[i]) begin
                errors++;
                $display("FAIL disable_word[%0d] got %h/%b want %h/%b", i, cap_data[base+i], cap_last[base+i], ew[i], el[i]);
            end
        end
        wait_idle();
        checks++;
        if (event_count !== 32'd14) begin
            errors++;
            $display("FAIL disable_count got %0d want 14", event_count);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        cfg_timeout = 16'd2;
        base = cap_cnt;
        push(64'h5555_6666_7777_8888);
        tick();
        tick();
        checks++;
        if (out_data !== 32'h7777_8888) begin
            errors++;
            $display("FAIL rmid_lo got %h want 77778888", out_data);
        end
        resetn = 1'b0;
        tick();
        checks++;
        if (fifo_pop !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'd0 || out_last !== 1'b0 ||
            busy !== 1'b0 || event_count !== 32'd0) begin
            errors++;
            $display("FAIL rmid_outputs got pop=%b valid=%b data=%h last=%b busy=%b count=%0d want all 0",
                     fifo_pop, out_valid, out_data, out_last, busy, event_count);
        end
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (cap_cnt !== base + 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_no_trailer got words=%0d busy=%b want 2 0", cap_cnt - base, busy);
        end
        push(64'h9999_AAAA_BBBB_CCCC);
        wait_words(base + 5, "rmid_next");
        checks++;
        if (cap_data[base+4] !== 32'hE701_0000 || cap_last[base+4] !== 1'b1) begin
            errors++;
            $display("FAIL rmid_trailer got %h/%b want e7010000/1", cap_data[base+4], cap_last[base+4]);
        end
        wait_idle();
    endtask

    task automatic test_wrap_zero();
        int base;
        logic [31:0] ew [$];
        logic        el [$];
        cfg_burst_len = 8'd1;
        cfg_timeout = 16'd0;
        force dut.seq = 16'hFFFF;
        tick();
        release dut.seq;
        base = cap_cnt;
        push(64'h0101_0101_0202_0202);
        push(64'h0303_0303_0404_0404);
        wait_words(base + 6, "wrap");
        ew = '{32'h0101_0101, 32'h0202_0202, 32'hE701_FFFF, 32'h0303_0303, 32'h0404_0404, 32'hE701_0000};
        el = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        wait_idle();
        cfg_burst_len = 8'd0;
        for (int i = 0; i < 17; i++) begin
            push({32'h7000_0000 + 32'(i), 32'h8000_0000 + 32'(i)});
            ew.push_back(32'h7000_0000 + 32'(i)); el.push_back(1'b0);
            ew.push_back(32'h8000_0000 + 32'(i)); el.push_back(1'b0);
            if (i == 15) begin ew.push_back(32'hE710_0001); el.push_back(1'b1); end
        end
        ew.push_back(32'hE701_0002); el.push_back(1'b1);
        wait_words(base + 42, "zero_len");
        for (int i = 0; i < 42; i++) begin
            checks++;
            if (cap_data[base+i] !== ew[i] || cap_last[base+i] !== el[i]) begin
                errors++;
                $display("FAIL wrap_word[%0d] got %h/%b want %h/%b", i, cap_data[base+i], cap_last[base+i], ew[i], el[i]);
            end
        end
        checks++;
        if (cap_cyc[base+2] - cap_cyc[base+1] !== 1 || cap_cyc[base+41] - cap_cyc[base+40] !== 2) begin
            errors++;
            $display("FAIL zero_timeout_gap got %0d/%0d want 1/2",
                     cap_cyc[base+2] - cap_cyc[base+1], cap_cyc[base+41] - cap_cyc[base+40]);
        end
        wait_idle();
        checks++;
        if (event_count !== 32'd20 || consec_pops !== 0) begin
            errors++;
            $display("FAIL wrap_count got count=%0d consec=%0d want 20 0", event_count, consec_pops);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_limit();
        test_backpressure();
        test_disable();
        test_reset_mid();
        test_wrap_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
